// File: rtl/game_health_pkg.sv
// Shared definitions for the player health runtime: state encoding and fixed widths.
package game_health_pkg;

    localparam int unsigned HP_W_DEF = 10;
    localparam int unsigned DMG_W    = 7;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } health_state_e;

endpackage

// File: rtl/player_health_runtime_tick_timer.sv
// tick_timer: loadable down-counter advanced by an enable, with a one-cycle expiry flag
// on the enable that takes it from 1 to 0. Load beats decrement; clear beats load.
module tick_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire_c
);

    logic [W-1:0] count;

    assign expire_c = dec && (count == W'(1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/player_health_runtime.sv
// Turns the player overlap level into damage events with i-frames, sprite blink and death.
// Optional health regeneration is built when HEALTH_REGEN_EN is defined.
module player_health_runtime
    import game_health_pkg::*;
#(
    parameter int unsigned HP_W         = HP_W_DEF,
    parameter int unsigned IFRAME_TICKS = 100,
    parameter int unsigned BLINK_TICKS  = 10
`ifdef HEALTH_REGEN_EN
    ,
    parameter int unsigned REGEN_DELAY  = 300,
    parameter int unsigned REGEN_PERIOD = 50
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_cs,
    input  logic             stage_reset,
    input  logic [HP_W-1:0]  healt_max,
    input  logic             hit,
    input  logic [DMG_W-1:0] damage,
    output logic [HP_W-1:0]  healt_current,
    output logic             invulnerable,
    output logic             player_visible,
    output logic             hit_pulse,
    output logic             dead
);

    localparam int unsigned IFRAME_W = $clog2(IFRAME_TICKS + 1);
    localparam int unsigned BLINK_W  = $clog2(BLINK_TICKS + 1);
    localparam int unsigned CMP_W    = (HP_W > DMG_W) ? HP_W : DMG_W;

    if (IFRAME_TICKS == 0) begin : g_bad_iframe
        $error("IFRAME_TICKS must be >= 1");
    end
    if (BLINK_TICKS == 0) begin : g_bad_blink
        $error("BLINK_TICKS must be >= 1");
    end

    health_state_e   state, state_d;
    logic [HP_W-1:0] health_d, max_q, max_d, hit_health;
    logic            visible_d, pulse_d;
    logic            hit_accept, inv_tick, iframe_exp, blink_exp;

    assign hit_accept = !stage_reset && (state == ALIVE) && hit;
    assign inv_tick   = !stage_reset && (state == INVULN) && tick_cs;

    tick_timer #(.W(IFRAME_W)) u_iframe (
        .clk      (clk),
        .reset    (reset),
        .clear    (stage_reset),
        .load     (hit_accept),
        .load_val (IFRAME_W'(IFRAME_TICKS)),
        .dec      (inv_tick),
        .expire_c (iframe_exp)
    );

    tick_timer #(.W(BLINK_W)) u_blink (
        .clk      (clk),
        .reset    (reset),
        .clear    (stage_reset),
        .load     (hit_accept || blink_exp),
        .load_val (BLINK_W'(BLINK_TICKS)),
        .dec      (inv_tick),
        .expire_c (blink_exp)
    );

`ifdef HEALTH_REGEN_EN
    if (REGEN_PERIOD == 0) begin : g_bad_period
        $error("REGEN_PERIOD must be >= 1");
    end

    // Quiet delay first, then a free-running period timer while regen_phase is set.
    localparam int unsigned QUIET_W = $clog2(REGEN_DELAY + 2);
    localparam int unsigned PER_W   = $clog2(REGEN_PERIOD + 1);

    logic regen_restart, alive_tick, regen_phase, quiet_exp, per_exp;

    assign regen_restart = stage_reset || hit_accept;
    assign alive_tick    = !stage_reset && (state == ALIVE) && !hit && tick_cs;

    tick_timer #(.W(QUIET_W)) u_quiet (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .load     (regen_restart),
        .load_val (QUIET_W'(REGEN_DELAY)),
        .dec      (alive_tick && !regen_phase),
        .expire_c (quiet_exp)
    );

    tick_timer #(.W(PER_W)) u_period (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .load     (regen_restart || per_exp),
        .load_val (PER_W'(REGEN_PERIOD)),
        .dec      (alive_tick && regen_phase),
        .expire_c (per_exp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            regen_phase <= 1'b0;
        end else if (regen_restart) begin
            regen_phase <= (REGEN_DELAY == 0);
        end else if (quiet_exp) begin
            regen_phase <= 1'b1;
        end
    end
`endif

    // Next-state and next-output logic; stage_reset overrides everything below it.
    always_comb begin
        state_d    = state;
        health_d   = healt_current;
        max_d      = max_q;
        visible_d  = player_visible;
        pulse_d    = 1'b0;
        hit_health = '0;
        if (CMP_W'(healt_current) > CMP_W'(damage)) begin
            hit_health = healt_current - HP_W'(damage);
        end

        if (stage_reset) begin
            max_d     = healt_max;
            health_d  = healt_max;
            visible_d = 1'b1;
            state_d   = (healt_max == '0) ? DEAD : ALIVE;
        end else begin
            unique case (state)
                ALIVE: begin
                    if (hit) begin
                        pulse_d  = 1'b1;
                        health_d = hit_health;
                        if (hit_health == '0) begin
                            state_d = DEAD;
                        end else begin
                            state_d   = INVULN;
                            visible_d = 1'b0;
                        end
                    end
`ifdef HEALTH_REGEN_EN
                    else if (per_exp && (healt_current < max_q)) begin
                        health_d = healt_current + HP_W'(1);
                    end
`endif
                end
                INVULN: begin
                    if (iframe_exp) begin
                        state_d   = ALIVE;
                        visible_d = 1'b1;
                    end else if (blink_exp) begin
                        visible_d = !player_visible;
                    end
                end
                DEAD: begin
                    health_d = '0;
                end
                default: begin
                    state_d = DEAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= DEAD;
            healt_current  <= '0;
            max_q          <= '0;
            invulnerable   <= 1'b0;
            player_visible <= 1'b1;
            hit_pulse      <= 1'b0;
            dead           <= 1'b1;
        end else begin
            state          <= state_d;
            healt_current  <= health_d;
            max_q          <= max_d;
            invulnerable   <= (state_d == INVULN);
            player_visible <= visible_d;
            hit_pulse      <= pulse_d;
            dead           <= (state_d == DEAD);
        end
    end

endmodule

// File: tb/tb_player_health_runtime.sv
// Randomized bench for player_health_runtime: stimulus pushes the expected outputs of a
// tick-counting reference model into a queue; a monitor compares one entry per clock.
module tb_player_health_runtime;

    localparam int unsigned HP_W   = 10;
    localparam int unsigned IFRAME = 100;
    localparam int unsigned BLINK  = 10;
`ifdef HEALTH_REGEN_EN
    localparam int unsigned RD = 300;
    localparam int unsigned RP = 50;
`endif

    localparam int M_ALIVE  = 0;
    localparam int M_INVULN = 1;
    localparam int M_DEAD   = 2;

    typedef struct packed {
        logic [HP_W-1:0] hp;
        logic            inv;
        logic            vis;
        logic            pulse;
        logic            dead;
    } obs_t;

    logic            clk;
    logic            reset;
    logic            tick_cs;
    logic            stage_reset;
    logic [HP_W-1:0] healt_max;
    logic            hit;
    logic [6:0]      damage;
    logic [HP_W-1:0] healt_current;
    logic            invulnerable;
    logic            player_visible;
    logic            hit_pulse;
    logic            dead;

    player_health_runtime #(
        .HP_W         (HP_W),
        .IFRAME_TICKS (IFRAME),
        .BLINK_TICKS  (BLINK)
`ifdef HEALTH_REGEN_EN
        ,
        .REGEN_DELAY  (RD),
        .REGEN_PERIOD (RP)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tick_cs        (tick_cs),
        .stage_reset    (stage_reset),
        .healt_max      (healt_max),
        .hit            (hit),
        .damage         (damage),
        .healt_current  (healt_current),
        .invulnerable   (invulnerable),
        .player_visible (player_visible),
        .hit_pulse      (hit_pulse),
        .dead           (dead)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Model: health plus "ticks since the hit" (k) and "quiet ticks since the hit" (q).
    int   m_st = M_DEAD;
    int   m_hp = 0;
    int   m_mx = 0;
    int   m_k  = 0;
    int   m_q  = 0;
    bit   m_vis = 1'b1;
    bit   m_pulse = 1'b0;

    task automatic step(input bit r, input bit sr, input int hm, input bit h, input int d, input bit t);
        obs_t e;
        @(negedge clk);
        reset       = r;
        stage_reset = sr;
        healt_max   = HP_W'(hm);
        hit         = h;
        damage      = 7'(d);
        tick_cs     = t;
        if (r) begin
            m_st = M_DEAD; m_hp = 0; m_mx = 0; m_vis = 1'b1; m_pulse = 1'b0; m_k = 0; m_q = 0;
        end else begin
            m_pulse = 1'b0;
            if (sr) begin
                m_mx = hm; m_hp = hm; m_vis = 1'b1; m_k = 0; m_q = 0;
                m_st = (hm == 0) ? M_DEAD : M_ALIVE;
            end else if (m_st == M_ALIVE) begin
                if (h) begin
                    m_pulse = 1'b1;
                    m_hp = (m_hp > d) ? m_hp - d : 0;
                    m_q = 0;
                    if (m_hp == 0) begin
                        m_st = M_DEAD;
                    end else begin
                        m_st = M_INVULN; m_k = 0; m_vis = 1'b0;
                    end
                end
`ifdef HEALTH_REGEN_EN
                else if (t) begin
                    m_q++;
                    if (m_q > int'(RD) && ((m_q - int'(RD)) % int'(RP)) == 0 && m_hp < m_mx) m_hp++;
                end
`endif
            end else if (m_st == M_INVULN && t) begin
                m_k++;
                if (m_k == int'(IFRAME)) begin
                    m_st = M_ALIVE; m_vis = 1'b1;
                end else begin
                    m_vis = ((m_k / int'(BLINK)) % 2) == 1;
                end
            end
        end
        e.hp    = HP_W'(m_hp);
        e.inv   = (m_st == M_INVULN);
        e.vis   = m_vis;
        e.pulse = m_pulse;
        e.dead  = (m_st == M_DEAD);
        exp_q.push_back(e);
    endtask

    function automatic int rdmg(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    function automatic bit coin(input int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    // Monitor: one expected entry per active edge, sampled 1 time unit after it.
    initial begin
        obs_t a, e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{hp: healt_current, inv: invulnerable, vis: player_visible,
                      pulse: hit_pulse, dead: dead};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d: got hp=%0d inv=%b vis=%b pulse=%b dead=%b, want hp=%0d inv=%b vis=%b pulse=%b dead=%b",
                             cyc, a.hp, a.inv, a.vis, a.pulse, a.dead, e.hp, e.inv, e.vis, e.pulse, e.dead);
                end
            end
        end
    end

    initial begin
        int rr;
        reset = 1'b1; stage_reset = 1'b0; healt_max = '0; hit = 1'b0; damage = '0; tick_cs = 1'b0;

        // Reset state, then idle: dead, zero health.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 5, 1);
        step(0, 0, 0, 1, 5, 1);

        // Load 92, single hit of 20, then a full i-frame window with blinking.
        step(0, 1, 92, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 20, 1);
        repeat (110) step(0, 0, 0, 0, rdmg(0, 127), 1);

        // Continuous overlap: one hit per i-frame window.
        repeat (700) step(0, 0, 0, 1, 5, coin(50));

        // Saturating lethal hit, then hits and ticks ignored until stage_reset.
        step(0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 1, 20, 0);
        repeat (40) step(0, 0, 0, coin(50), rdmg(0, 127), coin(50));
        step(0, 1, 92, 0, 0, 0);

        // Exact kill to zero.
        step(0, 1, 20, 0, 0, 0);
        step(0, 0, 0, 1, 20, 1);
        step(0, 1, 92, 0, 0, 0);

        // stage_reset wins over hit mid-INVULN.
        step(0, 0, 0, 1, 10, 0);
        repeat (15) step(0, 0, 0, 0, 0, 1);
        step(0, 1, 92, 1, 30, 1);
        repeat (3) step(0, 0, 0, 0, 0, 1);

        // Zero damage still pulses and grants i-frames; tick with the hit is not counted.
        step(0, 0, 0, 1, 0, 1);
        repeat (105) step(0, 0, 0, 0, 0, 1);

        // healt_max of zero lands directly in DEAD.
        step(0, 1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, rdmg(0, 127), 1);

`ifdef HEALTH_REGEN_EN
        // Regen from 72 back to 92, then a hit mid-regen restarts the delay.
        step(0, 1, 92, 0, 0, 0);
        step(0, 0, 0, 1, 20, 0);
        repeat (1600) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 30, 1);
        repeat (200) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 7, 0);
        repeat (600) step(0, 0, 0, 0, 0, 1);
`endif

        // Random mix of everything.
        step(0, 1, 500, 0, 0, 0);
        repeat (4000) begin
            rr = int'($urandom_range(999, 0));
            step(rr == 999, rr < 7, (rr == 0) ? 0 : rdmg(1, 1023), coin(15), rdmg(0, 40), coin(50));
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
